// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Optional SERSUB_OVF_EN adds the signed overflow flag.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
  logic             zero;
`ifdef SERSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERSUB_OVF_EN
    input  ovf,
`endif
    input  diff, bout, busy, done, zero
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERSUB_OVF_EN
    output ovf,
`endif
    output diff, bout, busy, done, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell plus a borrow FF, LSB first.
// Define SERSUB_OVF_EN to add the signed overflow output (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | shifting one bit per edge, WIDTH edges
  // DONE  | one-cycle done pulse, start accepted here too
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic             accept, last;
  logic             x, y, d, br_nxt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q;
`ifdef SERSUB_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign x       = a_sr[0];
  assign y       = b_sr[0];
  assign d       = x ^ y ^ br;
  assign br_nxt  = (~x & y) | (~(x ^ y) & br);
  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign res_nxt = {d, res_sr};

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      br   <= bus.bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt[WIDTH-1:1];
      br     <= br_nxt;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff_q <= res_nxt;
        bout_q <= br_nxt;
        zero_q <= (res_nxt == '0);
`ifdef SERSUB_OVF_EN
        // borrow into the MSB differs from borrow out => signed overflow
        ovf_q  <= br ^ br_nxt;
`endif
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
`ifdef SERSUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
